// File: rtl/stream_capture_fifo.sv
// Captures a valid-only upstream stream into a small FWFT FIFO and re-presents it on a valid/ready port.
// Words arriving while the FIFO is full are dropped. Each drop sets a sticky flag and bumps a saturating counter.
module stream_capture_fifo #(
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [DATA_WIDTH-1:0]        i_input_data,
  input  logic                         i_input_data_valid,
  output logic [DATA_WIDTH-1:0]        o_output_data,
  output logic                         o_output_data_valid,
  input  logic                         i_output_data_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_fill_level,
  output logic                         o_overflow,
  input  logic                         i_overflow_clear,
  output logic [DROP_CNT_WIDTH-1:0]    o_drop_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]         fill_q, fill_d;
  logic                      overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic full, push, pop, drop;

  // Downstream handshake: a word transfers on every rising edge where
  // o_output_data_valid and i_output_data_ready are both high. Valid comes
  // from registered fill only and never depends on ready or upstream valid.
  assign o_output_data_valid = (fill_q != '0);
  assign o_output_data       = mem_q[rd_ptr_q];
  assign o_fill_level        = fill_q;
  assign o_overflow          = overflow_q;
  assign o_drop_count        = drop_cnt_q;

  assign full = (fill_q == FILL_W'(DEPTH));
  assign pop  = o_output_data_valid && i_output_data_ready;
  assign push = i_input_data_valid && (!full || pop);
  assign drop = i_input_data_valid && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push && !pop)      fill_d = fill_q + FILL_W'(1);
    else if (pop && !push) fill_d = fill_q - FILL_W'(1);

    // A clear takes effect first, so a drop in the same cycle counts as 1.
    if (i_overflow_clear) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + DROP_CNT_WIDTH'(1);
    end
  end

  // Storage carries no reset; the fill count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_input_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule
